// File: rtl/brick_pkg.sv
// Shared types for the brick table: id/value types, controller states and
// the fixed level patterns written during a load.
package brick_pkg;

  localparam int NUM_BRICKS = 64;

  typedef logic [1:0] brick_t;
  typedef logic [5:0] brick_id_t;

  typedef enum logic {IDLE, LOAD} state_t;

  function automatic brick_t level_pattern(input logic [1:0] level,
                                           input logic [2:0] row,
                                           input logic [2:0] col);
    brick_t v;
    case (level)
      2'd0:    v = 2'd1;
      2'd1:    v = brick_t'(row % 3'd3) + 2'd1;
      2'd2:    v = (row[0] ^ col[0]) ? 2'd3 : 2'd2;
      default: v = ((row == 3'd0) || (row == 3'd7) || (col == 3'd0) || (col == 3'd7))
                   ? 2'd3 : 2'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/brick_table_ctrl_rr_arb2.sv
// Two-port round-robin arbiter: a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_valid
);

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    grant_valid = |eligible;
  end

endmodule

// File: rtl/brick_table_ctrl.sv
// Brick table owner: sequences level loads and serialises the two players'
// hit requests, tracking scores, remaining bricks and level-cleared.
module brick_table_ctrl
  import brick_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [1:0]              level_sel,
  input  logic [1:0]              hit_req,
  input  logic [5:0]              hit_id0,
  input  logic [5:0]              hit_id1,
  output logic [1:0]              hit_ack,
  output logic [1:0]              hit_prev,
  output logic [2*NUM_BRICKS-1:0] bricks,
  output logic [6:0]              remaining,
  output logic [SCORE_W-1:0]      score0,
  output logic [SCORE_W-1:0]      score1,
  output logic                    busy,
  output logic                    cleared
);

  state_t                  state, state_n;
  logic                    start_load, accept;
  logic [1:0]              level;
  brick_id_t               idx;
  brick_t [NUM_BRICKS-1:0] table_q;
  logic                    last_grant;
  logic [1:0]              eligible, grant;
  logic                    grant_valid;
  logic                    sel;
  brick_id_t               id;
  brick_t                  cur, pat;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  // A port still being acknowledged is masked so a held request is not taken twice.
  assign eligible = hit_req & ~hit_ack;

  rr_arb2 u_arb (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign sel    = grant[1];
  assign id     = sel ? hit_id1 : hit_id0;
  assign cur    = table_q[id];
  assign pat    = level_pattern(level, idx[5:3], idx[2:0]);
  assign bricks = table_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_load = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_n    = LOAD;
          start_load = 1'b1;
        end else begin
          accept = grant_valid;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (idx == 6'd63) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      table_q    <= '0;
      remaining  <= '0;
      score0     <= '0;
      score1     <= '0;
      hit_ack    <= '0;
      hit_prev   <= '0;
      cleared    <= 1'b0;
      level      <= '0;
      idx        <= '0;
      last_grant <= 1'b1;
    end else begin
      hit_ack <= '0;
      cleared <= 1'b0;
      if (start_load) begin
        level     <= level_sel;
        idx       <= '0;
        remaining <= '0;
      end else if (state == LOAD) begin
        table_q[idx] <= pat;
        remaining    <= remaining + {6'd0, (pat != 2'd0)};
        idx          <= idx + 6'd1;
      end else if (accept) begin
        last_grant <= sel;
        hit_ack    <= grant;
        hit_prev   <= cur;
        if (cur != 2'd0) begin
          table_q[id] <= cur - 2'd1;
          if (sel) score1 <= sat_inc(score1);
          else     score0 <= sat_inc(score0);
          // The brick empties only when its last point of strength is removed.
          if (cur == 2'd1) begin
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) cleared <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_brick_table_ctrl.sv
// Scoreboard bench for brick_table_ctrl: drivers queue hit ids, a monitor
// applies each acknowledged hit to a table model and compares all outputs.
module tb_brick_table_ctrl;

  localparam int SW      = 10;
  localparam int SAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [1:0]    level_sel = 2'd0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    hit_req;
  logic [5:0]    id0 = 6'd0, id1 = 6'd0;
  logic [1:0]    hit_ack, hit_prev;
  logic [127:0]  bricks;
  logic [6:0]    remaining;
  logic [SW-1:0] score0, score1;
  logic          busy, cleared;

  assign hit_req = {req1, req0};

  brick_table_ctrl #(.SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .level_sel(level_sel),
    .hit_req(hit_req), .hit_id0(id0), .hit_id1(id1), .hit_ack(hit_ack),
    .hit_prev(hit_prev), .bricks(bricks), .remaining(remaining),
    .score0(score0), .score1(score1), .busy(busy), .cleared(cleared)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  logic [1:0] m_tab [64];
  int m_rem = 0;
  int m_score [2];
  int q0 [$];
  int q1 [$];
  int clr_cnt = 0;
  int load_end_cyc = 0;
  int ack_cyc [2];
  logic prev_busy = 1'b0;
  int mp, mid, mv;
  logic exp_clr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pat(input int lv, input int r, input int c);
    case (lv)
      0:       return 1;
      1:       return (r % 3) + 1;
      2:       return ((r + c) % 2 == 1) ? 3 : 2;
      default: return (r == 0 || r == 7 || c == 0 || c == 7) ? 3 : 0;
    endcase
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int i = 0; i < 64; i++) v[2*i +: 2] = m_tab[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tab[i] = 2'd0;
    m_rem = 0;
    m_score[0] = 0;
    m_score[1] = 0;
    q0.delete();
    q1.delete();
  endtask

  // Monitor: every acknowledged hit is applied to the model in ack order.
  always @(negedge clk) begin
    if (!rst) begin
      prev_busy = 1'b0;
    end else begin
      exp_clr = 1'b0;
      if (prev_busy) chk("ack_during_load", 128'(hit_ack), 128'(0));
      if (hit_ack != 2'b00) begin
        chk("ack_onehot", 128'($onehot(hit_ack)), 128'(1));
        mp = hit_ack[1] ? 1 : 0;
        if ((mp == 0 && q0.size() == 0) || (mp == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: player %0d acked with nothing pending", mp);
        end else begin
          mid = (mp == 1) ? q1.pop_front() : q0.pop_front();
          mv  = int'(m_tab[mid]);
          chk("hit_prev", 128'(hit_prev), 128'(mv));
          if (mv != 0) begin
            m_tab[mid] = 2'(mv - 1);
            m_score[mp] = (m_score[mp] >= SAT_MAX) ? SAT_MAX : m_score[mp] + 1;
            if (mv == 1) begin
              m_rem--;
              exp_clr = (m_rem == 0);
            end
          end
          chk("bricks", bricks, model_vec());
          chk("remaining", 128'(remaining), 128'(m_rem));
          chk("score0", 128'(score0), 128'(m_score[0]));
          chk("score1", 128'(score1), 128'(m_score[1]));
        end
      end
      chk("cleared", 128'(cleared), 128'(exp_clr));
      if (cleared) clr_cnt++;
      prev_busy = busy;
    end
  end

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    load_start = 1'b0;
    rst = 1'b0;
    #13;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_load(input int lv);
    @(posedge clk); #1;
    load_start = 1'b1;
    level_sel  = 2'(lv);
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("busy_in_load", 128'(busy), 128'(1));
    end
    @(negedge clk);
    chk("busy_after_load", 128'(busy), 128'(0));
    load_end_cyc = cyc;
    m_rem = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        m_tab[r*8+c] = 2'(pat(lv, r, c));
        if (pat(lv, r, c) != 0) m_rem++;
      end
    chk("load_remaining", 128'(remaining), 128'(m_rem));
    chk("load_bricks", bricks, model_vec());
  endtask

  task automatic hit(input int p, input int id, output int lat);
    if (p == 0) q0.push_back(id);
    else        q1.push_back(id);
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1'b1; id0 = 6'(id); end
    else        begin req1 = 1'b1; id1 = 6'(id); end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (hit_ack[p[0]] == 1'b0 && lat < 300);
    if (hit_ack[p[0]] == 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: player %0d id %0d got no ack in %0d cycles", p, id, lat);
    end
    ack_cyc[p[0]] = cyc;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int l0, l1, lm;
    logic [127:0] bv;
    model_reset();
    #12;
    chk("rst_bricks", bricks, 128'(0));
    chk("rst_remaining", 128'(remaining), 128'(0));
    chk("rst_scores", 128'({score1, score0}), 128'(0));
    chk("rst_ack", 128'({hit_ack, hit_prev}), 128'(0));
    chk("rst_busy_cleared", 128'({busy, cleared}), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    do_load(0);
    chk("l0_remaining", 128'(remaining), 128'(64));

    do_load(3);
    bv = bricks;
    chk("l3_remaining", 128'(remaining), 128'(28));
    chk("l3_brick0", 128'(bv[1:0]), 128'(3));
    chk("l3_brick9", 128'(bv[19:18]), 128'(0));
    chk("l3_brick63", 128'(bv[127:126]), 128'(3));

    do_load(0);
    hit(0, 5, l0);
    bv = bricks;
    chk("lat_uncontested", 128'(l0), 128'(1));
    chk("hit5_prev", 128'(hit_prev), 128'(1));
    chk("hit5_brick", 128'(bv[11:10]), 128'(0));
    chk("hit5_remaining", 128'(remaining), 128'(63));
    chk("hit5_score0", 128'(score0), 128'(1));
    hit(0, 5, l0);
    chk("hit5_again_prev", 128'(hit_prev), 128'(0));
    chk("hit5_again_remaining", 128'(remaining), 128'(63));
    chk("hit5_again_score0", 128'(score0), 128'(1));

    do_reset();
    do_load(2);
    fork
      hit(0, 1, l0);
      hit(1, 1, l1);
    join
    bv = bricks;
    chk("tie_lat_p0", 128'(l0), 128'(1));
    chk("tie_lat_p1", 128'(l1), 128'(2));
    chk("tie_brick1", 128'(bv[3:2]), 128'(1));
    chk("tie_scores", 128'({score1, score0}), 128'({10'd1, 10'd1}));

    fork
      do_load(1);
      begin
        repeat (10) @(posedge clk);
        hit(0, 8, lm);
      end
    join
    chk("midload_ack_cycle", 128'(ack_cyc[0]), 128'(load_end_cyc + 1));

    @(posedge clk); #1;
    load_start = 1'b1;
    level_sel  = 2'd0;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_bricks", bricks, 128'(0));
    chk("abort_remaining", 128'(remaining), 128'(0));
    chk("abort_scores", 128'({score1, score0}), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ack", 128'({hit_ack, hit_prev, cleared}), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 128'({busy, remaining}), 128'(0));
    chk("abort_table_empty", bricks, 128'(0));

    clr_cnt = 0;
    do_load(3);
    fork
      begin
        int l;
        for (int i = 0; i < 64; i += 2)
          repeat (pat(3, i / 8, i % 8)) hit(0, i, l);
      end
      begin
        int l;
        for (int i = 1; i < 64; i += 2)
          repeat (pat(3, i / 8, i % 8)) hit(1, i, l);
      end
    join
    repeat (3) @(negedge clk);
    chk("clear_pulses", 128'(clr_cnt), 128'(1));
    chk("clear_remaining", 128'(remaining), 128'(0));
    chk("clear_bricks", bricks, 128'(0));

    for (int rnd = 0; rnd < 3; rnd++) begin
      do_load(int'($urandom_range(0, 3)));
      fork
        begin
          int l;
          for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            hit(0, int'($urandom_range(0, 63)), l);
          end
        end
        begin
          int l;
          for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            hit(1, int'($urandom_range(0, 63)), l);
          end
        end
      join
    end

    repeat (7) begin
      do_load(2);
      for (int i = 0; i < 64; i++)
        repeat (pat(2, i / 8, i % 8)) hit(0, i, l0);
    end
    repeat (3) @(negedge clk);
    chk("score0_saturated", 128'(score0), 128'(SAT_MAX));
    chk("queues_drained", 128'(q0.size() + q1.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
